add_seq_ctrl: RTL
=================

// Module: add_seq_ctrl
// PURPOSE
//  Sequencer that computes NBYTES*8-bit add/subtract on one shared 8-bit conditional-sum adder slice.
//  - Slice: A, B, CIN in; S, COUT out; purely combinational.
//  - Processes one byte per cycle, LSB first; chains carry through an internal register.
//  - Valid/ready request and response channels; sits between issue logic and the adder.
// PARAMETERS
//  NBYTES  4  operand width in bytes (W = 8*NBYTES); legal range 2..8
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request valid
//  req_ready  out  1   request accepted when req_valid & req_ready
//  req_a      in   W   operand A
//  req_b      in   W   operand B
//  req_cin    in   1   carry-in (add only)
//  req_sub    in   1   1: A-B (B inverted, initial carry forced 1, req_cin ignored)
//  add_a      out  8   to adder A
//  add_b      out  8   to adder B
//  add_cin    out  1   to adder CIN
//  add_s      in   8   from adder S
//  add_cout   in   1   from adder COUT
//  rsp_valid  out  1   result valid
//  rsp_ready  in   1   result consumed when rsp_valid & rsp_ready
//  rsp_sum    out  W   result
//  rsp_cout   out  1   final carry-out (sub: 1 = no borrow)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_sum=0; rsp_cout=0;
//    byte counter=0; carry reg=0; add_a/add_b/add_cin=0.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: req_ready=1. On req_valid:
//      - latch A; latch B (or ~B if req_sub);
//      - carry <= req_sub ? 1 : req_cin; cnt <= 0; go RUN.
//    RUN: req_ready=0.
//      - add_a/add_b = byte cnt of latched operands; add_cin = carry reg.
//      - Each edge: result byte cnt <= add_s; carry <= add_cout; cnt++.
//      - At cnt==NBYTES-1: go DONE.
//    DONE: rsp_valid=1; rsp_sum/rsp_cout held stable. On rsp_ready: go IDLE, rsp_valid=0.
//  - Adder inputs driven 0 outside RUN. Adder path is combinational within one cycle.
//  - Latency: accept at edge 0; bytes computed over edges 1..NBYTES; rsp_valid high from edge NBYTES.
//  - Throughput: min NBYTES+2 cycles/op; no accept while RUN or DONE.
//  - rsp_ready high when DONE entered: consumed that cycle; req_ready returns next cycle.
//  - rsp_ready held low: stay in DONE indefinitely; outputs and req_ready=0 stable.
//  - Arithmetic: modulo 2^W; rsp_cout = carry out of byte NBYTES-1.
//  - rsp_sum updates only in RUN; value persists after hand-off until the next op overwrites it.
//  - Reset asserted mid-RUN/DONE: op discarded, no response; IDLE with reset values on release.
// CONFIGURATION
//  SEQ_FLAGS_EN defined:
//   - adds ports rsp_zero (out 1) and rsp_ovf (out 1), valid with rsp_valid, 0 at reset.
//   - rsp_zero = (rsp_sum==0).
//   - rsp_ovf = signed overflow = carry into MSB XOR carry out of MSB.
//     Carry into MSB is add_s[7]^add_a[7]^add_b[7] on the last byte, registered.
//  SEQ_FLAGS_EN undefined: ports and flag logic absent; all else identical.
// TESTING (NBYTES=4)
//  - 0x000000FF + 0x00000001, cin=0 -> rsp_valid 4 cycles after accept;
//    sum=0x00000100, cout=0; carry crosses byte 0->1.
//  - 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1; zero=1, ovf=0 with SEQ_FLAGS_EN.
//  - sub: 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0; req_cin=1 ignored.
//  - 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0; ovf=1, zero=0 with SEQ_FLAGS_EN.
//  - rsp_ready low 3 cycles in DONE -> rsp_valid/sum stable, req_ready=0;
//    new req_valid not accepted until cycle after rsp_ready.
//  - rst_n low during RUN byte 2 -> immediate reset values; after release req_ready=1;
//    next op 1+2 -> sum=3.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Byte-serial NBYTES*8-bit add/subtract sequencer driving one external 8-bit adder slice.
// Optional SEQ_FLAGS_EN adds registered zero and signed-overflow result flags.
module add_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_cin,
    input  logic                  req_sub,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout
`ifdef SEQ_FLAGS_EN
   ,output logic                  rsp_zero,
    output logic                  rsp_ovf
`endif
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sum_next;
    logic            last;

    // Result bytes enter at the top and shift down, so after NBYTES steps byte 0 sits at the bottom.
    assign sum_next = {add_s, rsp_sum[W-1:8]};
    assign last     = (cnt == CW'(NBYTES - 1));

`ifdef SEQ_FLAGS_EN
    logic msb_cin;
    assign msb_cin = add_s[7] ^ add_a[7] ^ add_b[7];
`endif

    // add_cin doubles as the chained carry register while in RUN and is cleared elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            add_a     <= 8'd0;
            add_b     <= 8'd0;
            add_cin   <= 1'b0;
`ifdef SEQ_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= RUN;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        op_a      <= req_a >> 8;
                        op_b      <= (req_sub ? ~req_b : req_b) >> 8;
                        add_a     <= req_a[7:0];
                        add_b     <= req_sub ? ~req_b[7:0] : req_b[7:0];
                        add_cin   <= req_sub | req_cin;
                    end
                end
                RUN: begin
                    rsp_sum <= sum_next;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_cout  <= add_cout;
                        add_a     <= 8'd0;
                        add_b     <= 8'd0;
                        add_cin   <= 1'b0;
`ifdef SEQ_FLAGS_EN
                        rsp_zero  <= (sum_next == '0);
                        rsp_ovf   <= msb_cin ^ add_cout;
`endif
                    end else begin
                        add_a   <= op_a[7:0];
                        add_b   <= op_b[7:0];
                        add_cin <= add_cout;
                        op_a    <= op_a >> 8;
                        op_b    <= op_b >> 8;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
